// File: rtl/char_buf_if.sv
// Character-buffer scheduler bus bundle: scanout fetch, host write, clear, and buffer RAM port.
// slave = scheduler side, master = environment (scanout, host, RAM).
interface char_buf_if #(
  parameter int ADDR_W = 12
) ();
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [6:0]        disp_char;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [6:0]        host_char;
  logic              clear_req;
  logic [6:0]        clear_char;
  logic              clear_busy;
  logic              addr_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [6:0]        ram_wdata;
  logic [6:0]        ram_rdata;

  modport slave (
    input  disp_req, disp_addr, host_valid, host_addr, host_char,
           clear_req, clear_char, ram_rdata,
    output disp_valid, disp_char, host_ready, clear_busy, addr_err,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, host_valid, host_addr, host_char,
           clear_req, clear_char, ram_rdata,
    input  disp_valid, disp_char, host_ready, clear_busy, addr_err,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/char_buf_scheduler.sv
// Arbitrates one single-port text buffer RAM between scanout reads, a whole-buffer fill and a 4-deep host write FIFO.
// Optional fill engine enabled by defining CHAR_BUF_CLEAR_EN.
module char_buf_scheduler #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic      pixel_clk,
  input  logic      pixel_rstn,
  char_buf_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_W:0] CELLS_X = (ADDR_W+1)'(CELLS);
  localparam int STAGES = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [6:0]        ch;
  } host_wr_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < CELLS_X;
  endfunction

  // host write FIFO
  host_wr_t   fifo_q [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       push, pop;
  host_wr_t   head;

  // scanout pipeline: request valid and "address was in range" per stage
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] ok_pipe;

  logic              clr_busy;
  logic              fill_wr;
  logic [ADDR_W-1:0] fill_addr;
  logic [6:0]        fill_char;

  logic disp_ok;
  assign disp_ok = in_range(bus.disp_addr);

`ifdef CHAR_BUF_CLEAR_EN
  typedef enum logic {IDLE, FILL} clr_state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [6:0]        code_q, code_d;

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    fill_wr = 1'b0;
    case (state_q)
      IDLE: if (bus.clear_req) begin
        state_d = FILL;
        cnt_d   = '0;
        code_d  = bus.clear_char;
      end
      FILL: if (!bus.disp_req) begin
        // scanout steals the slot; the fill just stalls for that cycle
        fill_wr = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy  = (state_q == FILL);
  assign fill_addr = cnt_q;
  assign fill_char = code_q;
`else
  logic unused_clr;
  assign unused_clr = ^{bus.clear_req, bus.clear_char};
  assign clr_busy   = 1'b0;
  assign fill_wr    = 1'b0;
  assign fill_addr  = '0;
  assign fill_char  = '0;
`endif

  assign bus.clear_busy = clr_busy;
  assign bus.host_ready = (count != 3'd4);
  assign push = bus.host_valid && bus.host_ready;
  assign pop  = (count != 3'd0) && !bus.disp_req && !clr_busy;
  assign head = fifo_q[rd_ptr];

  always_ff @(posedge pixel_clk) begin
    if (!pixel_rstn) begin
      vld_pipe       <= '0;
      ok_pipe        <= '0;
      bus.disp_valid <= 1'b0;
      bus.disp_char  <= '0;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.addr_err   <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      vld_pipe       <= {vld_pipe[STAGES-1:0], bus.disp_req};
      ok_pipe        <= {ok_pipe[STAGES-1:0], bus.disp_req && disp_ok};
      bus.disp_valid <= vld_pipe[STAGES];
      bus.disp_char  <= ok_pipe[STAGES] ? bus.ram_rdata : 7'd0;

      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      if (bus.disp_req) begin
        if (disp_ok) begin
          bus.ram_en   <= 1'b1;
          bus.ram_addr <= bus.disp_addr;
        end
      end else if (fill_wr) begin
        bus.ram_en    <= 1'b1;
        bus.ram_we    <= 1'b1;
        bus.ram_addr  <= fill_addr;
        bus.ram_wdata <= fill_char;
      end else if (pop && in_range(head.addr)) begin
        bus.ram_en    <= 1'b1;
        bus.ram_we    <= 1'b1;
        bus.ram_addr  <= head.addr;
        bus.ram_wdata <= head.ch;
      end

      if ((bus.disp_req && !disp_ok) || (pop && !in_range(head.addr)))
        bus.addr_err <= 1'b1;

      if (push) begin
        fifo_q[wr_ptr] <= '{addr: bus.host_addr, ch: bus.host_char};
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end
endmodule

// File: tb/tb_char_buf_scheduler.sv
// Directed bench for char_buf_scheduler with a synchronous single-port RAM model and write log.
module tb_char_buf_scheduler;
  localparam int AW = 12;

  logic clk;
  logic rstn;
  char_buf_if #(.ADDR_W(AW)) bus ();

  char_buf_scheduler #(.COLS(80), .ROWS(30), .ADDR_W(AW)) dut (
    .pixel_clk (clk),
    .pixel_rstn(rstn),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0]    mem [0:4095];
  int            log_addr[$];
  int            log_data[$];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [6:0]    poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        log_addr.push_back(int'(bus.ram_addr));
        log_data.push_back(int'(bus.ram_wdata));
      end else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    bus.host_valid = 1'b0;
    bus.host_addr  = '0;
    bus.host_char  = '0;
    bus.clear_req  = 1'b0;
    bus.clear_char = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic poke(input int a, input int d);
    poke_addr = AW'(a);
    poke_data = 7'(d);
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW+AW+13:0] outs;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    outs = {bus.disp_valid, bus.disp_char, bus.ram_en, bus.ram_we, bus.ram_addr,
            bus.ram_wdata, bus.clear_busy, bus.addr_err};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready got %b want 1", bus.host_ready); end
  endtask

  task automatic test_scanout();
    do_reset();
    poke(5, 'h41);
    bus.disp_req = 1'b1; bus.disp_addr = 12'd5;
    bus.host_valid = 1'b1; bus.host_addr = 12'd5; bus.host_char = 7'h11;
    tick();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 12'd5}) begin
      errors++; $display("FAIL scan_read_slot got en=%b we=%b addr=%0d want 1 0 5", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    bus.disp_req = 1'b0; bus.host_valid = 1'b0;
    tick();
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 1'b1, 12'd5, 7'h11}) begin
      errors++; $display("FAIL scan_host_after got en=%b we=%b addr=%0d d=%h want 1 1 5 11", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL scan_early_valid got %b want 0", bus.disp_valid); end
    tick();
    checks++;
    if ({bus.disp_valid, bus.disp_char} !== {1'b1, 7'h41}) begin
      errors++; $display("FAIL scan_result got v=%b c=%h want 1 41", bus.disp_valid, bus.disp_char);
    end
    tick();
    checks++;
    if (bus.disp_valid !== 1'b0 || mem[5] !== 7'h11) begin
      errors++; $display("FAIL scan_after got v=%b mem5=%h want 0 11", bus.disp_valid, mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_res [3];
    exp_res[0] = {1'b1, 7'h0a}; exp_res[1] = {1'b1, 7'h00}; exp_res[2] = {1'b1, 7'h0b};
    do_reset();
    poke(10, 'h0a);
    poke(11, 'h0b);
    bus.disp_req = 1'b1; bus.disp_addr = 12'd10;
    tick();
    bus.disp_addr = 12'd2400;
    tick();
    checks++;
    if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL b2b_oor_access got ram_en=%b want 0", bus.ram_en); end
    bus.disp_addr = 12'd11;
    tick();
    bus.disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.disp_valid, bus.disp_char} !== exp_res[i]) begin
        errors++; $display("FAIL b2b_result%0d got %h want %h", i, {bus.disp_valid, bus.disp_char}, exp_res[i]);
      end
      tick();
    end
    checks++;
    if (bus.disp_valid !== 1'b0 || bus.addr_err !== 1'b1) begin
      errors++; $display("FAIL b2b_tail got v=%b err=%b want 0 1", bus.disp_valid, bus.addr_err);
    end
  endtask

  task automatic test_fifo_full();
    int start, idx, cyc, bad;
    logic acc;
    do_reset();
    start = log_addr.size();
    bus.disp_req = 1'b1; bus.disp_addr = 12'd0;
    for (int i = 0; i < 4; i++) begin
      bus.host_valid = 1'b1; bus.host_addr = AW'(100 + i); bus.host_char = 7'(8'h30 + i);
      checks++;
      if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL fifo_ready%0d got %b want 1", i, bus.host_ready); end
      tick();
    end
    bus.host_addr = 12'd104; bus.host_char = 7'h34;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL fifo_full%0d got %b want 0", i, bus.host_ready); end
      tick();
    end
    checks++;
    if (log_addr.size() != start) begin errors++; $display("FAIL fifo_no_drain got %0d writes want 0", log_addr.size() - start); end
    bus.disp_req = 1'b0;
    idx = 4; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      bus.host_valid = 1'b1; bus.host_addr = AW'(100 + idx); bus.host_char = 7'(8'h30 + idx);
      acc = bus.host_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.host_valid = 1'b0;
    cyc = 0;
    while (log_addr.size() < start + 6 && cyc < 40) begin tick(); cyc++; end
    checks++;
    if (log_addr.size() != start + 6) begin
      errors++; $display("FAIL fifo_write_count got %0d want 6", log_addr.size() - start);
    end else begin
      bad = 0;
      for (int k = 0; k < 6; k++)
        if (log_addr[start+k] != 100 + k || log_data[start+k] != 'h30 + k) bad++;
      if (bad != 0) begin errors++; $display("FAIL fifo_order got %0d misordered want 0", bad); end
    end
  endtask

  task automatic test_addr_err();
    int start;
    do_reset();
    start = log_addr.size();
    bus.host_valid = 1'b1; bus.host_addr = 12'd2399; bus.host_char = 7'h21;
    tick();
    bus.host_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus.addr_err !== 1'b0 || mem[2399] !== 7'h21) begin
      errors++; $display("FAIL err_last_cell got err=%b mem=%h want 0 21", bus.addr_err, mem[2399]);
    end
    start = log_addr.size();
    bus.host_valid = 1'b1; bus.host_addr = 12'd2400; bus.host_char = 7'h12;
    tick();
    bus.host_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus.addr_err !== 1'b1 || log_addr.size() != start) begin
      errors++; $display("FAIL err_oor_write got err=%b writes=%0d want 1 0", bus.addr_err, log_addr.size() - start);
    end
    bus.host_valid = 1'b1; bus.host_addr = 12'd7; bus.host_char = 7'h33;
    tick();
    bus.host_valid = 1'b0;
    tick(); tick();
    checks++;
    if (bus.addr_err !== 1'b1 || mem[7] !== 7'h33 || log_addr.size() != start + 1) begin
      errors++; $display("FAIL err_sticky got err=%b mem7=%h writes=%0d want 1 33 1", bus.addr_err, mem[7], log_addr.size() - start);
    end
  endtask

`ifdef CHAR_BUF_CLEAR_EN
  task automatic test_clear();
    int start, cyc, busy_cnt, bad;
    do_reset();
    start = log_addr.size();
    bus.clear_char = 7'h20; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0; bus.clear_char = 7'h41;
    busy_cnt = 0; cyc = 0;
    while (bus.clear_busy && cyc < 3000) begin
      busy_cnt++;
      bus.host_valid = (cyc == 500); bus.host_addr = 12'd3; bus.host_char = 7'h7f;
      bus.clear_req  = (cyc == 1000);
      tick();
      cyc++;
    end
    bus.host_valid = 1'b0; bus.clear_req = 1'b0;
    checks++;
    if (busy_cnt != 2400) begin errors++; $display("FAIL clear_busy_len got %0d want 2400", busy_cnt); end
    cyc = 0;
    while (log_addr.size() < start + 2401 && cyc < 20) begin tick(); cyc++; end
    tick(); tick();
    checks++;
    if (log_addr.size() != start + 2401) begin
      errors++; $display("FAIL clear_write_count got %0d want 2401", log_addr.size() - start);
    end else begin
      bad = 0;
      for (int k = 0; k < 2400; k++)
        if (log_addr[start+k] != k || log_data[start+k] != 'h20) bad++;
      if (log_addr[start+2400] != 3 || log_data[start+2400] != 'h7f) bad++;
      if (bad != 0) begin errors++; $display("FAIL clear_contents got %0d bad writes want 0", bad); end
    end
  endtask

  task automatic test_clear_reset();
    int cyc;
    do_reset();
    poke(100, 'h55);
    poke(101, 'h55);
    bus.clear_char = 7'h2a; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    cyc = 0;
    while (!(bus.ram_we && bus.ram_addr == 12'd99) && cyc < 500) begin tick(); cyc++; end
    checks++;
    if (cyc >= 500) begin errors++; $display("FAIL clrrst_reach99 got timeout want fill at 99"); end
    rstn = 1'b0;
    tick();
    checks++;
    if ({bus.clear_busy, bus.ram_we, bus.host_ready} !== 3'b001) begin
      errors++; $display("FAIL clrrst_state got busy=%b we=%b rdy=%b want 0 0 1", bus.clear_busy, bus.ram_we, bus.host_ready);
    end
    rstn = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (mem[101] !== 7'h55 || mem[100] !== 7'h55 || mem[99] !== 7'h2a || bus.clear_busy !== 1'b0) begin
      errors++; $display("FAIL clrrst_mem got m99=%h m100=%h m101=%h busy=%b want 2a 55 55 0", mem[99], mem[100], mem[101], bus.clear_busy);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int start;
    do_reset();
    start = log_addr.size();
    bus.clear_char = 7'h20; bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    checks++;
    if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL noclr_busy got %b want 0", bus.clear_busy); end
    tick(); tick(); tick();
    checks++;
    if (log_addr.size() != start || bus.clear_busy !== 1'b0) begin
      errors++; $display("FAIL noclr_writes got %0d writes busy=%b want 0 0", log_addr.size() - start, bus.clear_busy);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_scanout();
    test_back_to_back();
    test_fifo_full();
    test_addr_err();
`ifdef CHAR_BUF_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
